// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request/response front-end and sole master of a single-port RAM.
// After reset it optionally fills every RAM word with FILL_VAL. It then accepts
// read/write requests over valid/ready, issues one per cycle to the RAM
// (1-cycle read latency) and returns read data through a small response FIFO.
// A credit scheme (FIFO occupancy + in-flight read) keeps the FIFO from overflowing.
//
// Ports:
//   clka, rsta              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_we/req_addr/req_wdata payload
//   rsp_valid/rsp_ready     response handshake; rsp_rdata/rsp_err payload
//   init_done               high once the fill has completed
//   ram_ena/wea/addra/dina  RAM port drive; ram_douta read data back
module ram_req_ctrl #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 16,
  parameter bit                INIT_EN   = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VAL  = '0,
  parameter int                RSP_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]    CREDITS   = (CNT_W+1)'(RSP_DEPTH);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fill_cnt;
  logic                init_done_q;
  logic                inflight;
  logic                inflight_err;
  logic [DATA_W-1:0]   fifo_data [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic [CNT_W:0]      used;
  logic                accept;
  logic                in_range;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits come only from registered state, so rsp_ready never reaches req_ready.
  assign used      = {1'b0, count} + (CNT_W+1)'(inflight);
  assign req_ready = !rsta && (state == S_READY) && (used < CREDITS);
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_X;

  // The read issued last cycle has its data on ram_douta now.
  assign push      = inflight;
  assign rsp_valid = !rsta && (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_data[head] : '0;
  assign rsp_err   = rsp_valid && fifo_err[head];

  // With no fill phase the block is usable as soon as reset is released.
  assign init_done = init_done_q || (!INIT_EN && !rsta);

  // RAM port: fill writes during INIT, otherwise the accepted request passes
  // straight through. Out-of-range requests never touch the RAM.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (!rsta) begin
      if (state == S_INIT) begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = fill_cnt;
        ram_dina  = FILL_VAL;
      end else if (accept && in_range) begin
        ram_ena   = 1'b1;
        ram_wea   = req_we;
        ram_addra = req_addr;
        ram_dina  = req_wdata;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state        <= INIT_EN ? S_INIT : S_READY;
      fill_cnt     <= '0;
      init_done_q  <= 1'b0;
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      fifo_err     <= '0;
    end else begin
      if (state == S_INIT) begin
        fill_cnt <= fill_cnt + ADDR_W'(1);
        if (fill_cnt == LAST_ADDR) begin
          state       <= S_READY;
          init_done_q <= 1'b1;
        end
      end
      inflight     <= accept && !req_we;
      inflight_err <= accept && !req_we && !in_range;
      if (push) begin
        fifo_err[tail] <= inflight_err;
        tail           <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Data storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clka) begin
    if (!rsta && push) fifo_data[tail] <= inflight_err ? '0 : ram_douta;
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Testbench for ram_req_ctrl: a 16-word instance carries most scenarios, a
// 12-word instance covers out-of-range addressing. Behavioural RAMs sit on
// both ports; expected read data comes from a shadow memory updated on accept.
module tb_ram_req_ctrl;
  localparam logic [15:0] FILL = 16'h00A5;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic        rsta;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, init_done;
  logic [15:0] rsp_rdata;
  logic        ram_ena, ram_wea;
  logic [3:0]  ram_addra;
  logic [15:0] ram_dina, ram_douta;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [3:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_init_done;
  logic [15:0] b_rsp_rdata;
  logic        b_ram_ena, b_ram_wea;
  logic [3:0]  b_ram_addra;
  logic [15:0] b_ram_dina, b_ram_douta;

  ram_req_ctrl #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .INIT_EN(1'b1),
                 .FILL_VAL(FILL), .RSP_DEPTH(4)) u_dut (
    .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done), .ram_ena(ram_ena),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_douta(ram_douta));

  ram_req_ctrl #(.ADDR_W(4), .DATA_W(16), .DEPTH(12), .INIT_EN(1'b1),
                 .FILL_VAL(FILL), .RSP_DEPTH(4)) u_dut12 (
    .clka(clka), .rsta(rsta), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .init_done(b_init_done), .ram_ena(b_ram_ena),
    .ram_wea(b_ram_wea), .ram_addra(b_ram_addra), .ram_dina(b_ram_dina),
    .ram_douta(b_ram_douta));

  // Behavioural single-port RAMs, 1-cycle read latency.
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) mem_a[ram_addra] <= ram_dina;
      else         ram_douta <= mem_a[ram_addra];
    end
    if (b_ram_ena) begin
      if (b_ram_wea) mem_b[b_ram_addra] <= b_ram_dina;
      else           b_ram_douta <= mem_b[b_ram_addra];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: contents as seen by the requester, plus response queues.
  logic [15:0] shadow [16];
  logic [15:0] exp_d[$];
  logic [15:0] got_d[$];
  bit          got_e[$];
  int          got_cyc[$];

  task automatic model_init();
    for (int i = 0; i < 16; i++) shadow[i] = FILL;
    exp_d.delete(); got_d.delete(); got_e.delete(); got_cyc.delete();
  endtask

  // Sample handshakes in the low phase, update the model, advance one cycle.
  task automatic tick(output bit acc);
    #1;
    acc = req_valid && req_ready;
    if (acc) begin
      if (req_we) shadow[req_addr] = req_wdata;
      else        exp_d.push_back(shadow[req_addr]);
    end
    if (rsp_valid && rsp_ready) begin
      got_d.push_back(rsp_rdata);
      got_e.push_back(rsp_err);
      got_cyc.push_back(cyc);
    end
    @(posedge clka);
    cyc++;
    @(negedge clka);
  endtask

  task automatic issue(input bit we, input logic [3:0] addr, input logic [15:0] d,
                       output int at);
    bit acc;
    at = -1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d;
    for (int k = 0; k < 50; k++) begin
      tick(acc);
      if (acc) begin at = cyc - 1; break; end
    end
    req_valid = 1'b0;
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL issue_timeout: addr=%0d not accepted within 50 cycles", addr);
    end
  endtask

  task automatic drain();
    bit acc;
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 60 && got_d.size() < exp_d.size(); k++) tick(acc);
    tick(acc); tick(acc);
  endtask

  task automatic test_reset();
    bit acc;
    rsta = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    tick(acc); tick(acc);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || init_done !== 1'b0 ||
        ram_ena !== 1'b0 || ram_wea !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b done=%b ena=%b wea=%b rd=%h err=%b, required all 0",
               req_ready, rsp_valid, init_done, ram_ena, ram_wea, rsp_rdata, rsp_err);
    end
    rsta = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (ram_ena !== 1'b1 || ram_wea !== 1'b1 || ram_addra !== 4'(i) ||
          ram_dina !== FILL || req_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_write: cycle %0d ena=%b wea=%b addr=%0d din=%h rdy=%b done=%b, required 1 1 %0d %h 0 0",
                 i, ram_ena, ram_wea, ram_addra, ram_dina, req_ready, init_done, i, FILL);
      end
      tick(acc);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || ram_ena !== 1'b0) begin
      errors++;
      $display("FAIL init_done: done=%b rdy=%b ena=%b, required 1 1 0", init_done, req_ready, ram_ena);
    end
    model_init();
  endtask

  task automatic test_init_read();
    int at;
    logic [3:0] order [16];
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      int j;
      logic [3:0] t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue(1'b0, order[i], 16'h0, at);
    drain();
    checks++;
    if (got_d.size() != 16) begin
      errors++;
      $display("FAIL init_read_count: got %0d responses, required 16", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      checks++;
      if (got_d[i] !== FILL || got_e[i] !== 1'b0) begin
        errors++;
        $display("FAIL init_read_data: rsp %0d data=%h err=%b, required %h 0", i, got_d[i], got_e[i], FILL);
      end
    end
    model_init();
  endtask

  task automatic test_raw();
    int wat, rat;
    bit acc;
    rsp_ready = 1'b1;
    issue(1'b1, 4'd3, 16'h1234, wat);
    issue(1'b0, 4'd3, 16'h0, rat);
    checks++;
    if (rat != wat + 1) begin
      errors++;
      $display("FAIL raw_b2b: read accepted at %0d, write at %0d, required consecutive", rat, wat);
    end
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_early: rsp_valid=%b one cycle after accept, required 0", rsp_valid);
    end
    tick(acc);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL raw_data: vld=%b data=%h err=%b two cycles after accept, required 1 1234 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    tick(acc);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_single: rsp_valid=%b after the response, required 0", rsp_valid);
    end
    drain();
    checks++;
    if (got_d.size() != 1) begin
      errors++;
      $display("FAIL raw_count: got %0d responses, required 1", got_d.size());
    end
    exp_d.delete(); got_d.delete(); got_e.delete(); got_cyc.delete();
  endtask

  task automatic test_back_to_back();
    int at, first, drops;
    bit acc;
    for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 16'($urandom), at);
    drain();
    rsp_ready = 1'b1;
    drops = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'($urandom_range(0, 15));
      #1;
      if (req_ready !== 1'b1) drops++;
      if (first < 0) first = cyc;
      tick(acc);
    end
    req_valid = 1'b0;
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL b2b_ready: req_ready low in %0d of 20 cycles, required 0", drops);
    end
    drain();
    checks++;
    if (got_d.size() != 20 || exp_d.size() != 20) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses for %0d reads, required 20", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_e[i] !== 1'b0 || got_cyc[i] != first + 2 + i) begin
        errors++;
        $display("FAIL b2b_rsp: rsp %0d data=%h err=%b cyc=%0d, required %h 0 %0d",
                 i, got_d[i], got_e[i], got_cyc[i], exp_d[i], first + 2 + i);
      end
    end
    exp_d.delete(); got_d.delete(); got_e.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    int accepts;
    bit acc;
    rsp_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'($urandom_range(0, 15));
      tick(acc);
      if (acc) accepts++;
    end
    #1;
    checks++;
    if (accepts != 4 || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_credit: accepted %0d rdy=%b vld=%b, required 4 0 1", accepts, req_ready, rsp_valid);
    end
    drain();
    checks++;
    if (got_d.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d responses, required 4", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL bp_data: rsp %0d data=%h, required %h", i, got_d[i], exp_d[i]);
      end
    end
    exp_d.delete(); got_d.delete(); got_e.delete(); got_cyc.delete();
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 200; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 4'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick(acc);
    end
    drain();
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d responses, required %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_e[i] !== 1'b0) begin
        errors++;
        $display("FAIL rand_data: rsp %0d data=%h err=%b, required %h 0", i, got_d[i], got_e[i], exp_d[i]);
      end
    end
    exp_d.delete(); got_d.delete(); got_e.delete(); got_cyc.delete();
  endtask

  task automatic test_out_of_range();
    bit acc;
    logic [3:0] addrs [3];
    addrs[0] = 4'd13; addrs[1] = 4'd11; addrs[2] = 4'd12;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 4'd13; b_req_wdata = 16'hBEEF;
    #1;
    checks++;
    if (b_init_done !== 1'b1 || b_req_ready !== 1'b1 || b_ram_ena !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: done=%b rdy=%b ena=%b, required 1 1 0", b_init_done, b_req_ready, b_ram_ena);
    end
    tick(acc);
    for (int k = 0; k < 3; k++) begin
      logic [15:0] ed;
      logic        ee;
      ee = (addrs[k] >= 4'd12);
      ed = ee ? 16'h0 : FILL;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = addrs[k];
      #1;
      checks++;
      if (b_req_ready !== 1'b1 || b_ram_ena !== !ee || (!ee && (b_ram_wea !== 1'b0 || b_ram_addra !== addrs[k]))) begin
        errors++;
        $display("FAIL oor_issue: addr %0d rdy=%b ena=%b wea=%b a=%0d, required ena=%b", addrs[k],
                 b_req_ready, b_ram_ena, b_ram_wea, b_ram_addra, !ee);
      end
      tick(acc);
      b_req_valid = 1'b0;
      #1;
      checks++;
      if (b_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL oor_early: addr %0d rsp_valid=%b, required 0", addrs[k], b_rsp_valid);
      end
      tick(acc);
      #1;
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== ed || b_rsp_err !== ee) begin
        errors++;
        $display("FAIL oor_rsp: addr %0d vld=%b data=%h err=%b, required 1 %h %b", addrs[k],
                 b_rsp_valid, b_rsp_rdata, b_rsp_err, ed, ee);
      end
      tick(acc);
    end
  endtask

  task automatic test_reset_mid();
    int at;
    bit acc;
    drain();
    rsp_ready = 1'b0;
    issue(1'b0, 4'd5, 16'h0, at);
    issue(1'b0, 4'd6, 16'h0, at);
    rsta = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ram_ena !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: vld=%b rdy=%b ena=%b during reset, required 0 0 0", rsp_valid, req_ready, ram_ena);
    end
    tick(acc);
    rsta = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ram_ena !== 1'b1 || ram_addra !== 4'(i) || rsp_valid !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_init1: cycle %0d ena=%b addr=%0d vld=%b done=%b, required 1 %0d 0 0",
                 i, ram_ena, ram_addra, rsp_valid, init_done, i);
      end
      tick(acc);
    end
    rsta = 1'b1;
    tick(acc);
    rsta = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (ram_ena !== 1'b1 || ram_wea !== 1'b1 || ram_addra !== 4'(i) || ram_dina !== FILL ||
          rsp_valid !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_init2: cycle %0d ena=%b addr=%0d din=%h vld=%b done=%b, required 1 %0d %h 0 0",
                 i, ram_ena, ram_addra, ram_dina, rsp_valid, init_done, i, FILL);
      end
      tick(acc);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || got_d.size() != 0) begin
      errors++;
      $display("FAIL mid_done: done=%b rdy=%b stale=%0d, required 1 1 0", init_done, req_ready, got_d.size());
    end
    model_init();
    issue(1'b0, 4'd3, 16'h0, at);
    issue(1'b0, 4'd5, 16'h0, at);
    drain();
    checks++;
    if (got_d.size() != 2 || got_d[0] !== FILL || got_d[1] !== FILL) begin
      errors++;
      $display("FAIL mid_refill: %0d responses, first=%h, required 2 of %h",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 16'h0, FILL);
    end
    model_init();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rsta = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    model_init();
    test_reset();
    test_init_read();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
